// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU command encodings,
// controller state encoding and command classification helpers.
// The optional error-reporting feature is enabled with ALU_SHARE_ERR_EN.
package alu_ctrl_pkg;

  localparam int CMD_BITS = 4;

  localparam logic [CMD_BITS-1:0] CMD_ADD = 4'b0000;
  localparam logic [CMD_BITS-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_BITS-1:0] CMD_AND = 4'b0100;
  localparam logic [CMD_BITS-1:0] CMD_OR  = 4'b0101;
  localparam logic [CMD_BITS-1:0] CMD_NOR = 4'b0110;
  localparam logic [CMD_BITS-1:0] CMD_XOR = 4'b0111;
  localparam logic [CMD_BITS-1:0] CMD_SLL = 4'b1000;
  localparam logic [CMD_BITS-1:0] CMD_SRL = 4'b1010;
  localparam logic [CMD_BITS-1:0] CMD_SRA = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Shift commands only look at the low five bits of operand B.
  function automatic logic is_shift(input logic [CMD_BITS-1:0] cmd);
    return (cmd == CMD_SLL) || (cmd == CMD_SRL) || (cmd == CMD_SRA);
  endfunction

  // True for every command the ALU actually implements.
  function automatic logic is_legal_cmd(input logic [CMD_BITS-1:0] cmd);
    logic legal;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_NOR,
      CMD_XOR, CMD_SLL, CMD_SRL, CMD_SRA: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bundle of request, response and ALU-side signals for the ALU sharing
// controller. The slave modport is the controller itself; the master modport
// is the surrounding pipeline (both requesters plus the ALU).
// ALU_SHARE_ERR_EN adds the per-port error flags.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CMD_W-1:0] req0_cmd;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CMD_W-1:0] req1_cmd;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CMD_W-1:0] alu_cmd;
  logic [WIDTH-1:0] alu_out;

`ifdef ALU_SHARE_ERR_EN
  logic             rsp0_err;
  logic             rsp1_err;
`endif

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd,
    input  req1_valid, req1_a, req1_b, req1_cmd,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready,
`ifdef ALU_SHARE_ERR_EN
    output rsp0_err, rsp1_err,
`endif
    output alu_a, alu_b, alu_cmd,
    input  alu_out
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd,
    output req1_valid, req1_a, req1_b, req1_cmd,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready,
`ifdef ALU_SHARE_ERR_EN
    input  rsp0_err, rsp1_err,
`endif
    input  alu_a, alu_b, alu_cmd,
    output alu_out
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The last-granted port loses a tie, and
// the pointer only moves when the owner actually wins a transaction (advance).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic lastGrant_q;
  logic lastGrant_d;

  // A lone requester always wins; on a tie the port that was not served last
  // wins, so starting lastGrant at 1 lets port 0 take the first tie.
  always_comb begin
    grant       = 2'b00;
    lastGrant_d = lastGrant_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (advance) begin
      lastGrant_d = grant[1];
    end
  end

  // Pointer register, set so that port 0 is preferred after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one execute-stage ALU between the EXE instruction path (port 0) and
// the address/branch-compare helper (port 1). One operation is in flight at a
// time: IDLE accepts a request, EXEC lets the ALU settle on registered
// operands and captures its result, RESP holds the result until consumed.
// Defining ALU_SHARE_ERR_EN flags illegal commands and zeroes their result.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input logic              clk,
  input logic              rst,
  alu_share_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] aluA_q, aluA_d;
  logic [WIDTH-1:0] aluB_q, aluB_d;
  logic [CMD_W-1:0] aluCmd_q, aluCmd_d;
  logic [WIDTH-1:0] rspData0_q, rspData0_d;
  logic [WIDTH-1:0] rspData1_q, rspData1_d;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] selA, selB;
  logic [CMD_W-1:0] selCmd;
  logic [1:0]       grant;
  logic             take0, take1;
  logic             advance;
`ifdef ALU_SHARE_ERR_EN
  logic             rspErr0_q, rspErr0_d;
  logic             rspErr1_q, rspErr1_d;
  logic             errNow;
`endif

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  // Next-state, handshake and capture logic. Shift amounts are trimmed to
  // five bits on the way into the operand register so the ALU never sees an
  // out-of-range shift.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    aluA_d         = aluA_q;
    aluB_d         = aluB_q;
    aluCmd_d       = aluCmd_q;
    rspData0_d     = rspData0_q;
    rspData1_d     = rspData1_q;
    take0          = 1'b0;
    take1          = 1'b0;
    advance        = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    selA           = grant[1] ? bus.req1_a   : bus.req0_a;
    selB           = grant[1] ? bus.req1_b   : bus.req0_b;
    selCmd         = grant[1] ? bus.req1_cmd : bus.req0_cmd;
    capture        = bus.alu_out;
`ifdef ALU_SHARE_ERR_EN
    rspErr0_d      = rspErr0_q;
    rspErr1_d      = rspErr1_q;
    errNow         = !is_legal_cmd(aluCmd_q);
    if (errNow) begin
      capture = '0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (!rst) begin
          take0 = grant[0];
          take1 = grant[1];
        end
        if (take0 || take1) begin
          advance  = 1'b1;
          owner_d  = take1;
          aluA_d   = selA;
          aluB_d   = is_shift(selCmd) ? {{(WIDTH-5){1'b0}}, selB[4:0]} : selB;
          aluCmd_d = selCmd;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          rspData1_d = capture;
`ifdef ALU_SHARE_ERR_EN
          rspErr1_d  = errNow;
`endif
        end else begin
          rspData0_d = capture;
`ifdef ALU_SHARE_ERR_EN
          rspErr0_d  = errNow;
`endif
        end
        state_d = RESP;
      end
      RESP: begin
        bus.rsp0_valid = !owner_q;
        bus.rsp1_valid = owner_q;
        if ((!owner_q && bus.rsp0_ready) || (owner_q && bus.rsp1_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    bus.req0_ready = take0;
    bus.req1_ready = take1;
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluCmd_q   <= '0;
      rspData0_q <= '0;
      rspData1_q <= '0;
`ifdef ALU_SHARE_ERR_EN
      rspErr0_q  <= 1'b0;
      rspErr1_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluCmd_q   <= aluCmd_d;
      rspData0_q <= rspData0_d;
      rspData1_q <= rspData1_d;
`ifdef ALU_SHARE_ERR_EN
      rspErr0_q  <= rspErr0_d;
      rspErr1_q  <= rspErr1_d;
`endif
    end
  end

  assign bus.alu_a     = aluA_q;
  assign bus.alu_b     = aluB_q;
  assign bus.alu_cmd   = aluCmd_q;
  assign bus.rsp0_data = rspData0_q;
  assign bus.rsp1_data = rspData1_q;
`ifdef ALU_SHARE_ERR_EN
  assign bus.rsp0_err  = rspErr0_q;
  assign bus.rsp1_err  = rspErr1_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl. The bench plays the ALU and both
// requesters; a monitor predicts each response at request acceptance and
// checks it when the response is consumed. Build with ALU_SHARE_ERR_EN to
// also check the error flags.
module tb_alu_share_ctrl;

  localparam int WIDTH = 32;
  localparam int CMD_W = 4;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t expQ[$];
  int   servedLog[$];

  int compared   = 0;
  int mismatched = 0;
  int rspMode0   = 1;
  int rspMode1   = 1;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(WIDTH), .CMD_W(CMD_W)) bus ();

  alu_share_ctrl #(.WIDTH(WIDTH), .CMD_W(CMD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behaviour of the real ALU for each encoding; unknown codes give a
  // recognisable scramble of the operands.
  function automatic logic [31:0] aluFunc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    case (cmd)
      4'b0000: return a + b;
      4'b0010: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return ~(a | b);
      4'b0111: return a ^ b;
      4'b1000: return a << b;
      4'b1010: return a >> b;
      4'b1001: return $signed(a) >>> b;
      default: return a ^ b ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic bit isLegal(input logic [3:0] cmd);
    return cmd inside {4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
                       4'b0111, 4'b1000, 4'b1010, 4'b1001};
  endfunction

  // What the requester should eventually receive for one operation.
  function automatic exp_t predict(input int port, input op_t o);
    exp_t e;
    logic [31:0] bEff;
    bEff = (o.cmd inside {4'b1000, 4'b1010, 4'b1001}) ? (o.b % 32) : o.b;
    e.port = port;
    e.err  = 1'b0;
    e.data = aluFunc(o.cmd, o.a, bEff);
`ifdef ALU_SHARE_ERR_EN
    if (!isLegal(o.cmd)) begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end
`endif
    return e;
  endfunction

  always_comb bus.alu_out = aluFunc(bus.alu_cmd, bus.alu_a, bus.alu_b);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.cmd = cmd;
    o.a   = a;
    o.b   = b;
    if (port == 0) pend0.push_back(o);
    else           pend1.push_back(o);
  endtask

  task automatic checkResponse(input int port, input logic [31:0] data);
    exp_t e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL rsp%0d_unexpected: got data %0h, want no response", port, data);
      return;
    end
    e = expQ.pop_front();
    checkOutput($sformatf("rsp%0d_owner", port), 64'(port), 64'(e.port));
    checkOutput($sformatf("rsp%0d_data", port), 64'(data), 64'(e.data));
`ifdef ALU_SHARE_ERR_EN
    checkOutput($sformatf("rsp%0d_err", port),
                64'(port == 0 ? bus.rsp0_err : bus.rsp1_err), 64'(e.err));
`endif
  endtask

  // Requester 0: presents queued operations and holds each until accepted.
  initial begin
    bit  fired0;
    op_t o0;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_cmd   = '0;
    forever begin
      @(negedge clk);
      fired0 = bus.req0_valid && bus.req0_ready;
      @(posedge clk);
      #1;
      if (fired0 || !bus.req0_valid) begin
        if (pend0.size() > 0) begin
          o0 = pend0.pop_front();
          bus.req0_cmd   = o0.cmd;
          bus.req0_a     = o0.a;
          bus.req0_b     = o0.b;
          bus.req0_valid = 1'b1;
        end else begin
          bus.req0_valid = 1'b0;
        end
      end
    end
  end

  // Requester 1: same protocol as requester 0.
  initial begin
    bit  fired1;
    op_t o1;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_cmd   = '0;
    forever begin
      @(negedge clk);
      fired1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (fired1 || !bus.req1_valid) begin
        if (pend1.size() > 0) begin
          o1 = pend1.pop_front();
          bus.req1_cmd   = o1.cmd;
          bus.req1_a     = o1.a;
          bus.req1_b     = o1.b;
          bus.req1_valid = 1'b1;
        end else begin
          bus.req1_valid = 1'b0;
        end
      end
    end
  end

  // Response-side readiness: mode 0 stalls, 1 always ready, 2 random.
  initial begin
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp0_ready = (rspMode0 == 1) || (rspMode0 == 2 && $urandom_range(0, 2) != 0);
      bus.rsp1_ready = (rspMode1 == 1) || (rspMode1 == 2 && $urandom_range(0, 2) != 0);
    end
  end

  // Monitor: checks arbitration fairness at acceptance, queues the predicted
  // result, then checks latency, hold-under-stall and the consumed result.
  initial begin
    int          lastServed;
    int          fireAge;
    int          served;
    int          wantPort;
    logic        prevV0, prevV1, prevR0, prevR1;
    logic [31:0] prevD0, prevD1;
    op_t         o;
    lastServed = 1;
    fireAge    = 100;
    prevV0 = 1'b0; prevV1 = 1'b0; prevR0 = 1'b0; prevR1 = 1'b0;
    prevD0 = '0;   prevD1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        lastServed = 1;
        fireAge    = 100;
        prevV0     = 1'b0;
        prevV1     = 1'b0;
      end else begin
        fireAge++;
        checkOutput("rsp_valid_both", 64'(bus.rsp0_valid && bus.rsp1_valid), 64'd0);
        checkOutput("req_ready_both", 64'(bus.req0_ready && bus.req1_ready), 64'd0);
        if (prevV0 && !prevR0) begin
          checkOutput("rsp0_hold_valid", 64'(bus.rsp0_valid), 64'd1);
          checkOutput("rsp0_hold_data", 64'(bus.rsp0_data), 64'(prevD0));
        end
        if (prevV1 && !prevR1) begin
          checkOutput("rsp1_hold_valid", 64'(bus.rsp1_valid), 64'd1);
          checkOutput("rsp1_hold_data", 64'(bus.rsp1_data), 64'(prevD1));
        end
        if (bus.rsp0_valid && !prevV0) checkOutput("rsp0_latency", 64'(fireAge), 64'd2);
        if (bus.rsp1_valid && !prevV1) checkOutput("rsp1_latency", 64'(fireAge), 64'd2);
        if (bus.rsp0_valid && bus.rsp0_ready) checkResponse(0, bus.rsp0_data);
        if (bus.rsp1_valid && bus.rsp1_ready) checkResponse(1, bus.rsp1_data);
        if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
          served = bus.req1_ready ? 1 : 0;
          if (bus.req0_valid && bus.req1_valid) wantPort = 1 - lastServed;
          else                                  wantPort = bus.req0_valid ? 0 : 1;
          checkOutput("grant_port", 64'(served), 64'(wantPort));
          lastServed = served;
          servedLog.push_back(served);
          if (served == 0) begin
            o.cmd = bus.req0_cmd; o.a = bus.req0_a; o.b = bus.req0_b;
          end else begin
            o.cmd = bus.req1_cmd; o.a = bus.req1_a; o.b = bus.req1_b;
          end
          expQ.push_back(predict(served, o));
          fireAge = 0;
        end
        prevV0 = bus.rsp0_valid; prevR0 = bus.rsp0_ready; prevD0 = bus.rsp0_data;
        prevV1 = bus.rsp1_valid; prevR1 = bus.rsp1_ready; prevD1 = bus.rsp1_data;
      end
    end
  end

  task automatic waitFire(input int port, input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port == 0 && bus.req0_valid && bus.req0_ready) return;
      if (port == 1 && bus.req1_valid && bus.req1_ready) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got no acceptance on port %0d, want one within 30 cycles", name, port);
  endtask

  task automatic waitIdle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pend0.size() == 0 && pend1.size() == 0 && !bus.req0_valid && !bus.req1_valid &&
          expQ.size() == 0 && !bus.rsp0_valid && !bus.rsp1_valid) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got work still pending, want drained within %0d cycles", name, budget);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req0_ready"}, 64'(bus.req0_ready), 64'd0);
    checkOutput({tag, "_req1_ready"}, 64'(bus.req1_ready), 64'd0);
    checkOutput({tag, "_rsp0_valid"}, 64'(bus.rsp0_valid), 64'd0);
    checkOutput({tag, "_rsp1_valid"}, 64'(bus.rsp1_valid), 64'd0);
    checkOutput({tag, "_rsp0_data"},  64'(bus.rsp0_data),  64'd0);
    checkOutput({tag, "_rsp1_data"},  64'(bus.rsp1_data),  64'd0);
    checkOutput({tag, "_alu_a"},      64'(bus.alu_a),      64'd0);
    checkOutput({tag, "_alu_b"},      64'(bus.alu_b),      64'd0);
    checkOutput({tag, "_alu_cmd"},    64'(bus.alu_cmd),    64'd0);
`ifdef ALU_SHARE_ERR_EN
    checkOutput({tag, "_rsp0_err"},   64'(bus.rsp0_err),   64'd0);
    checkOutput({tag, "_rsp1_err"},   64'(bus.rsp1_err),   64'd0);
`endif
  endtask

  // Global watchdog in case a wait inside the DUT protocol never resolves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] legalCmds [9];
    logic [3:0] cmd;
    logic [31:0] bCap;
    legalCmds = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
                  4'b0111, 4'b1000, 4'b1010, 4'b1001};

    // Power-on reset values.
    @(negedge clk);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single ADD from port 0 with cycle-exact timing.
    applyStimulus(0, 4'b0000, 32'd5, 32'd7);
    waitFire(0, "add_accept");
    @(negedge clk);
    checkOutput("add_alu_cmd", 64'(bus.alu_cmd), 64'd0);
    checkOutput("add_alu_a", 64'(bus.alu_a), 64'd5);
    checkOutput("add_alu_b", 64'(bus.alu_b), 64'd7);
    checkOutput("add_rsp0_early", 64'(bus.rsp0_valid), 64'd0);
    @(negedge clk);
    checkOutput("add_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
    checkOutput("add_rsp0_data", 64'(bus.rsp0_data), 64'd12);
    checkOutput("add_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    waitIdle(50, "add_drain");

    // Tie from reset, then strict alternation over four operations.
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(0, 4'b0010, 32'd10, 32'd3);
    applyStimulus(1, 4'b0111, 32'hF0F0_0000, 32'hFFFF_FFFF);
    applyStimulus(0, 4'b0000, 32'd1, 32'd2);
    applyStimulus(1, 4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F);
    repeat (2) @(posedge clk);
    servedLog.delete();
    #1 rst = 1'b0;
    waitIdle(100, "tie_drain");
    checkOutput("tie_count", 64'(servedLog.size()), 64'd4);
    if (servedLog.size() == 4) begin
      checkOutput("tie_order0", 64'(servedLog[0]), 64'd0);
      checkOutput("tie_order1", 64'(servedLog[1]), 64'd1);
      checkOutput("tie_order2", 64'(servedLog[2]), 64'd0);
      checkOutput("tie_order3", 64'(servedLog[3]), 64'd1);
    end

    // Response backpressure on port 1 while port 0 waits.
    @(posedge clk);
    #1 rspMode1 = 0;
    applyStimulus(1, 4'b0000, 32'd100, 32'd23);
    waitFire(1, "bp_accept");
    applyStimulus(0, 4'b0101, 32'h0000_00F0, 32'h0000_000F);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
      checkOutput("bp_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
      checkOutput("bp_rsp1_data", 64'(bus.rsp1_data), 64'd123);
    end
    @(posedge clk);
    #1 rspMode1 = 1;
    begin : waitRsp1
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.rsp1_valid && bus.rsp1_ready) disable waitRsp1;
      end
      compared++;
      mismatched++;
      $display("[TB] FAIL bp_release: got no rsp1 handshake, want one within 10 cycles");
    end
    @(negedge clk);
    checkOutput("bp_req0_after", 64'(bus.req0_ready), 64'd1);
    waitIdle(50, "bp_drain");

    // Shift amounts wrap to five bits before reaching the ALU.
    applyStimulus(0, 4'b1000, 32'd1, 32'h0000_0021);
    waitFire(0, "sll_accept");
    @(negedge clk);
    bCap = bus.alu_b;
    checkOutput("sll_alu_b", 64'(bCap), 64'd1);
    waitIdle(50, "sll_drain");
    applyStimulus(0, 4'b1001, 32'h8000_0000, 32'd4);
    waitFire(0, "sra_accept");
    @(negedge clk);
    checkOutput("sra_alu_b", 64'(bus.alu_b), 64'd4);
    waitIdle(50, "sra_drain");

    // Reset while the operation is executing, then a fresh tie.
    applyStimulus(0, 4'b0000, 32'd3, 32'd4);
    waitFire(0, "rst_accept");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetState("midrst");
    applyStimulus(1, 4'b0110, 32'h1234_5678, 32'h0);
    applyStimulus(0, 4'b0010, 32'd0, 32'd1);
    @(posedge clk);
    @(posedge clk);
    servedLog.delete();
    #1 rst = 1'b0;
    waitIdle(50, "midrst_drain");
    checkOutput("midrst_first", 64'(servedLog.size() > 0 ? servedLog[0] : 9), 64'd0);

`ifdef ALU_SHARE_ERR_EN
    // Illegal command is flagged and zeroed; a legal AND is not.
    applyStimulus(0, 4'b0011, 32'hDEAD_BEEF, 32'h1);
    applyStimulus(1, 4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F);
    waitIdle(50, "err_drain");
`endif

    // Randomised traffic with random response stalls on both ports.
    @(posedge clk);
    #1;
    rspMode0 = 2;
    rspMode1 = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) cmd = 4'($urandom_range(0, 15));
      else                           cmd = legalCmds[$urandom_range(0, 8)];
      applyStimulus($urandom_range(0, 1), cmd, $urandom, $urandom);
    end
    waitIdle(3000, "random_drain");
    rspMode0 = 1;
    rspMode1 = 1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
